// File: rtl/operand_fetch_pkg.sv
// Shared constants, types and the forwarding helper for the operand fetch stage.
package operand_fetch_pkg;

   localparam int unsigned TOTAL_REG = 32;
   localparam int unsigned WIDTH_REG = 32;
   localparam int unsigned ADDR_W    = 5;

   typedef logic [ADDR_W-1:0]    regIdx_t;
   typedef logic [WIDTH_REG-1:0] regData_t;
   typedef logic [ADDR_W:0]      regCount_t;

   typedef struct packed {
      regData_t op1;
      regData_t op2;
      regIdx_t  dr;
      logic     wen;
   } opBundle_t;

   // Writeback landing this cycle beats the bank, which only sees it after the edge.
   function automatic regData_t fwdSelect(input logic     wbValid,
                                          input regIdx_t  wbDr,
                                          input regData_t wbData,
                                          input regIdx_t  src,
                                          input regData_t rdData);
      return (wbValid && (wbDr == src)) ? wbData : rdData;
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, execute, writeback and register-bank signals of the operand fetch stage.
interface operand_fetch_if;
   import operand_fetch_pkg::*;

   logic      in_valid;
   logic      in_ready;
   regIdx_t   in_sr1;
   regIdx_t   in_sr2;
   regIdx_t   in_dr;
   logic      in_wen;

   regIdx_t   rf_sr1;
   regIdx_t   rf_sr2;
   regData_t  rf_rdData1;
   regData_t  rf_rdData2;
   logic      rf_write;
   regIdx_t   rf_dr;
   regData_t  rf_wrData;

   logic      out_valid;
   logic      out_ready;
   regData_t  out_op1;
   regData_t  out_op2;
   regIdx_t   out_dr;
   logic      out_wen;

   logic      wb_valid;
   regIdx_t   wb_dr;
   regData_t  wb_data;

   regCount_t outstanding;
   logic      sb_err;

   // Environment side: decode, execute and the register bank.
   modport master (
      output in_valid, in_sr1, in_sr2, in_dr, in_wen,
      output rf_rdData1, rf_rdData2,
      output out_ready,
      output wb_valid, wb_dr, wb_data,
      input  in_ready, rf_sr1, rf_sr2, rf_write, rf_dr, rf_wrData,
      input  out_valid, out_op1, out_op2, out_dr, out_wen,
      input  outstanding, sb_err
   );

   modport slave (
      input  in_valid, in_sr1, in_sr2, in_dr, in_wen,
      input  rf_rdData1, rf_rdData2,
      input  out_ready,
      input  wb_valid, wb_dr, wb_data,
      output in_ready, rf_sr1, rf_sr2, rf_write, rf_dr, rf_wrData,
      output out_valid, out_op1, out_op2, out_dr, out_wen,
      output outstanding, sb_err
   );

endinterface

// File: rtl/operand_scoreboard.sv
// Pending-destination scoreboard: hazard detection, outstanding count and sticky error flag.
module operand_scoreboard
   import operand_fetch_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      accept,
   input  logic      inWen,
   input  regIdx_t   inDr,
   input  regIdx_t   inSr1,
   input  regIdx_t   inSr2,
   input  logic      wbValid,
   input  regIdx_t   wbDr,
   output logic      hazard,
   output regCount_t outstanding,
   output logic      sbErr
);

   logic [TOTAL_REG-1:0] pendingQ, pendingD;
   regCount_t            outstandingQ, outstandingD;
   logic                 sbErrQ, sbErrD;
   logic                 hz1, hz2, hzw, wbHit, setPend;

   always_comb begin
      // Sources may bypass a same-cycle writeback; a WAW destination never does.
      hz1     = pendingQ[inSr1] && !(wbValid && (wbDr == inSr1));
      hz2     = pendingQ[inSr2] && !(wbValid && (wbDr == inSr2));
      hzw     = inWen && pendingQ[inDr];
      hazard  = hz1 || hz2 || hzw;

      wbHit   = wbValid && pendingQ[wbDr];
      setPend = accept && inWen;

      pendingD = pendingQ;
      if (wbValid) begin
         pendingD[wbDr] = 1'b0;
      end
      if (setPend) begin
         pendingD[inDr] = 1'b1;
      end

      outstandingD = outstandingQ;
      if (setPend && !wbHit) begin
         outstandingD = outstandingQ + regCount_t'(1);
      end else if (!setPend && wbHit) begin
         outstandingD = outstandingQ - regCount_t'(1);
      end

      sbErrD = sbErrQ || (wbValid && !pendingQ[wbDr]);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pendingQ     <= '0;
         outstandingQ <= '0;
         sbErrQ       <= 1'b0;
      end else begin
         pendingQ     <= pendingD;
         outstandingQ <= outstandingD;
         sbErrQ       <= sbErrD;
      end
   end

   assign outstanding = outstandingQ;
   assign sbErr       = sbErrQ;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: decode handshake, writeback forwarding and registered operand bundle to execute.
module operand_fetch
   import operand_fetch_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   operand_fetch_if.slave bus
);

   opBundle_t bundleQ, bundleD;
   logic      outValidQ, outValidD;
   logic      hazard, accept;

   operand_scoreboard u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .accept      (accept),
      .inWen       (bus.in_wen),
      .inDr        (bus.in_dr),
      .inSr1       (bus.in_sr1),
      .inSr2       (bus.in_sr2),
      .wbValid     (bus.wb_valid),
      .wbDr        (bus.wb_dr),
      .hazard      (hazard),
      .outstanding (bus.outstanding),
      .sbErr       (bus.sb_err)
   );

   assign bus.rf_sr1    = bus.in_sr1;
   assign bus.rf_sr2    = bus.in_sr2;
   assign bus.rf_write  = reset && bus.wb_valid;
   assign bus.rf_dr     = bus.wb_dr;
   assign bus.rf_wrData = bus.wb_data;

   assign bus.in_ready = reset && (!outValidQ || bus.out_ready) && !hazard;
   assign accept       = bus.in_valid && bus.in_ready;

   always_comb begin
      bundleD   = bundleQ;
      outValidD = outValidQ;
      if (accept) begin
         bundleD.op1 = fwdSelect(bus.wb_valid, bus.wb_dr, bus.wb_data, bus.in_sr1,
                                 bus.rf_rdData1);
         bundleD.op2 = fwdSelect(bus.wb_valid, bus.wb_dr, bus.wb_data, bus.in_sr2,
                                 bus.rf_rdData2);
         bundleD.dr  = bus.in_dr;
         bundleD.wen = bus.in_wen;
         outValidD   = 1'b1;
      end else if (outValidQ && bus.out_ready) begin
         // Payload is left in place after a drain; only the valid flag drops.
         outValidD = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         bundleQ   <= '0;
         outValidQ <= 1'b0;
      end else begin
         bundleQ   <= bundleD;
         outValidQ <= outValidD;
      end
   end

   assign bus.out_valid = outValidQ;
   assign bus.out_op1   = bundleQ.op1;
   assign bus.out_op2   = bundleQ.op2;
   assign bus.out_dr    = bundleQ.dr;
   assign bus.out_wen   = bundleQ.wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand sequences and a randomized model check.
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   operand_fetch_if bus ();

   operand_fetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Register bank environment plus an independent copy driven from the bench's own writebacks.
   regData_t bank  [TOTAL_REG];
   regData_t mbank [TOTAL_REG];
   assign bus.rf_rdData1 = bank[bus.rf_sr1];
   assign bus.rf_rdData2 = bank[bus.rf_sr2];
   always @(posedge clk) if (bus.rf_write) bank[bus.rf_dr] <= bus.rf_wrData;
   always @(posedge clk) if (reset && bus.wb_valid) mbank[bus.wb_dr] <= bus.wb_data;

   int nChecks = 0;
   int nErrors = 0;

   typedef struct {
      logic v; regIdx_t s1; regIdx_t s2; regIdx_t d; logic w;
      logic wbv; regIdx_t wbd; regData_t wbdat;
      logic eRdy; logic eOutV; regData_t eOp1; regData_t eOp2; regIdx_t eDr; logic eWen;
      int eCnt; logic eErr;
   } vec_t;
   vec_t vecs [11];

   // Reference model state for the random phase.
   bit        pend [TOTAL_REG];
   logic      mOutV, mErr;
   opBundle_t mOut;

   logic      rv, rw, rordy, rwbv, eRdy, acc;
   regIdx_t   rs1, rs2, rd, rwbd;
   regData_t  rwbdat, eOp1, eOp2, expA1, expA2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input regIdx_t s1, input regIdx_t s2, input regIdx_t d,
                        input logic w, input logic ordy, input logic wbv, input regIdx_t wbd,
                        input regData_t wbdat);
      bus.in_valid  = v;
      bus.in_sr1    = s1;
      bus.in_sr2    = s2;
      bus.in_dr     = d;
      bus.in_wen    = w;
      bus.out_ready = ordy;
      bus.wb_valid  = wbv;
      bus.wb_dr     = wbd;
      bus.wb_data   = wbdat;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int popPend();
      int n = 0;
      for (int i = 0; i < TOTAL_REG; i++) n += int'(pend[i]);
      return n;
   endfunction

   function automatic regIdx_t pickReg();
      if ($urandom_range(0, 3) != 0) return regIdx_t'($urandom_range(0, 7));
      return regIdx_t'($urandom_range(0, TOTAL_REG - 1));
   endfunction

   initial begin
      //          v s1 s2 d w  wbv wbd wbdat  rdy outV op1    op2    dr wen cnt err
      vecs[0]  = '{1, 3, 4, 5, 1, 0, 0, 0,      1, 1, 'h11, 'h22, 5, 1, 1, 0};
      vecs[1]  = '{1, 5, 4, 6, 0, 0, 0, 0,      0, 0, 'h11, 'h22, 5, 1, 1, 0};
      vecs[2]  = '{1, 5, 4, 6, 0, 0, 0, 0,      0, 0, 'h11, 'h22, 5, 1, 1, 0};
      vecs[3]  = '{1, 5, 4, 6, 0, 1, 5, 'hAB,   1, 1, 'hAB, 'h22, 6, 0, 0, 0};
      vecs[4]  = '{1, 5, 5, 7, 1, 0, 0, 0,      1, 1, 'hAB, 'hAB, 7, 1, 1, 0};
      vecs[5]  = '{1, 3, 4, 7, 1, 0, 0, 0,      0, 0, 'hAB, 'hAB, 7, 1, 1, 0};
      vecs[6]  = '{1, 3, 4, 7, 1, 1, 7, 'h77,   0, 0, 'hAB, 'hAB, 7, 1, 0, 0};
      vecs[7]  = '{1, 3, 4, 7, 1, 1, 7, 'h78,   1, 1, 'h11, 'h22, 7, 1, 1, 1};
      vecs[8]  = '{1, 7, 3, 8, 0, 0, 0, 0,      0, 0, 'h11, 'h22, 7, 1, 1, 1};
      vecs[9]  = '{1, 7, 3, 8, 0, 1, 7, 'h99,   1, 1, 'h99, 'h11, 8, 0, 0, 1};
      vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 'h99, 'h11, 8, 0, 0, 1};

      // Reset state, with requests on the inputs that must be ignored.
      reset = 1'b0;
      drive(1, 1, 2, 3, 1, 1, 1, 9, 32'hDEAD);
      chk("reset_in_ready", 32'(bus.in_ready), 32'(0));
      chk("reset_rf_write", 32'(bus.rf_write), 32'(0));
      step();
      step();
      chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
      chk("reset_outstanding", 32'(bus.outstanding), 32'(0));
      chk("reset_sb_err", 32'(bus.sb_err), 32'(0));
      chk("reset_out_op1", bus.out_op1, 32'(0));
      chk("reset_out_dr", 32'(bus.out_dr), 32'(0));

      // Preload the bank through the writeback path, then reset away the resulting sb_err.
      reset = 1'b1;
      for (int i = 0; i < TOTAL_REG; i++) begin
         drive(0, 0, 0, 0, 0, 1, 1, regIdx_t'(i),
               (i == 3) ? 32'h11 : (i == 4) ? 32'h22 : $urandom);
         step();
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk("preload_sb_err", 32'(bus.sb_err), 32'(1));
      reset = 1'b0;
      step();
      reset = 1'b1;

      // Directed table: basic issue, RAW forwarding, WAW stall, set-wins.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].v, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].w, 1,
               vecs[i].wbv, vecs[i].wbd, vecs[i].wbdat);
         chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].eRdy));
         chk($sformatf("vec%0d_rf_write", i), 32'(bus.rf_write), 32'(vecs[i].wbv));
         step();
         chk($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].eOutV));
         chk($sformatf("vec%0d_out_op1", i), bus.out_op1, vecs[i].eOp1);
         chk($sformatf("vec%0d_out_op2", i), bus.out_op2, vecs[i].eOp2);
         chk($sformatf("vec%0d_out_dr", i), 32'(bus.out_dr), 32'(vecs[i].eDr));
         chk($sformatf("vec%0d_out_wen", i), 32'(bus.out_wen), 32'(vecs[i].eWen));
         chk($sformatf("vec%0d_outstanding", i), 32'(bus.outstanding), 32'(vecs[i].eCnt));
         chk($sformatf("vec%0d_sb_err", i), 32'(bus.sb_err), 32'(vecs[i].eErr));
      end

      // Backpressure: payload must hold for three stalled cycles, then stream at full rate.
      drive(1, 1, 2, 10, 0, 0, 0, 0, 0);
      chk("bp_first_ready", 32'(bus.in_ready), 32'(1));
      expA1 = mbank[1];
      expA2 = mbank[2];
      step();
      for (int k = 0; k < 3; k++) begin
         drive(1, 3, 4, 11, 1, 0, 0, 0, 0);
         chk($sformatf("bp%0d_in_ready", k), 32'(bus.in_ready), 32'(0));
         step();
         chk($sformatf("bp%0d_out_valid", k), 32'(bus.out_valid), 32'(1));
         chk($sformatf("bp%0d_out_op1", k), bus.out_op1, expA1);
         chk($sformatf("bp%0d_out_op2", k), bus.out_op2, expA2);
         chk($sformatf("bp%0d_out_dr", k), 32'(bus.out_dr), 32'(10));
      end
      drive(1, 3, 4, 11, 1, 1, 0, 0, 0);
      chk("bp_release_ready", 32'(bus.in_ready), 32'(1));
      step();
      chk("bp_release_op1", bus.out_op1, 32'h11);
      chk("bp_release_dr", 32'(bus.out_dr), 32'(11));
      for (int k = 0; k < 4; k++) begin
         drive(1, regIdx_t'(12 + k), regIdx_t'(16 + k), regIdx_t'(24 + k), 1, 1, 0, 0, 0);
         chk($sformatf("stream%0d_in_ready", k), 32'(bus.in_ready), 32'(1));
         step();
         chk($sformatf("stream%0d_out_valid", k), 32'(bus.out_valid), 32'(1));
         chk($sformatf("stream%0d_out_op1", k), bus.out_op1, mbank[12 + k]);
         chk($sformatf("stream%0d_out_op2", k), bus.out_op2, mbank[16 + k]);
         chk($sformatf("stream%0d_out_dr", k), 32'(bus.out_dr), 32'(24 + k));
         chk($sformatf("stream%0d_outstanding", k), 32'(bus.outstanding), 32'(2 + k));
      end

      // Reset mid-operation with five destinations pending and a bundle waiting.
      reset = 1'b0;
      drive(1, 1, 2, 3, 0, 0, 1, 11, 32'hBAD0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'(0));
      chk("midrst_rf_write", 32'(bus.rf_write), 32'(0));
      step();
      chk("midrst_out_valid", 32'(bus.out_valid), 32'(0));
      chk("midrst_outstanding", 32'(bus.outstanding), 32'(0));
      chk("midrst_sb_err", 32'(bus.sb_err), 32'(0));
      reset = 1'b1;

      // Writeback to a register nobody is waiting on.
      drive(0, 0, 0, 0, 0, 1, 1, 9, 32'h5A5A);
      chk("stray_rf_write", 32'(bus.rf_write), 32'(1));
      chk("stray_rf_dr", 32'(bus.rf_dr), 32'(9));
      chk("stray_rf_wrData", bus.rf_wrData, 32'h5A5A);
      step();
      chk("stray_sb_err", 32'(bus.sb_err), 32'(1));
      chk("stray_outstanding", 32'(bus.outstanding), 32'(0));
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
         step();
         chk($sformatf("stray_sticky%0d", k), 32'(bus.sb_err), 32'(1));
      end
      drive(1, 11, 9, 0, 0, 1, 0, 0, 0);
      chk("postrst_ready", 32'(bus.in_ready), 32'(1));
      step();
      chk("postrst_op1", bus.out_op1, mbank[11]);
      chk("postrst_op2", bus.out_op2, 32'h5A5A);

      // Randomized traffic against the reference model.
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
      step();
      reset = 1'b1;
      for (int i = 0; i < TOTAL_REG; i++) pend[i] = 1'b0;
      mOutV = 1'b0;
      mErr  = 1'b0;
      mOut  = '0;
      for (int c = 0; c < 400; c++) begin
         rv     = ($urandom_range(0, 3) != 0);
         rs1    = pickReg();
         rs2    = pickReg();
         rd     = pickReg();
         rw     = 1'($urandom_range(0, 1));
         rordy  = ($urandom_range(0, 3) != 0);
         rwbv   = 1'b0;
         rwbd   = '0;
         rwbdat = $urandom;
         if (popPend() > 0 && $urandom_range(0, 2) == 0) begin
            int k = $urandom_range(0, popPend() - 1);
            for (int i = 0; i < TOTAL_REG; i++) begin
               if (pend[i]) begin
                  if (k == 0) rwbd = regIdx_t'(i);
                  k--;
               end
            end
            rwbv = 1'b1;
         end else if ($urandom_range(0, 49) == 0) begin
            rwbv = 1'b1;
            rwbd = pickReg();
         end

         eRdy = !(mOutV && !rordy)
                && !(pend[rs1] && !(rwbv && rwbd == rs1))
                && !(pend[rs2] && !(rwbv && rwbd == rs2))
                && !(rw && pend[rd]);
         eOp1 = (rwbv && rwbd == rs1) ? rwbdat : mbank[rs1];
         eOp2 = (rwbv && rwbd == rs2) ? rwbdat : mbank[rs2];

         drive(rv, rs1, rs2, rd, rw, rordy, rwbv, rwbd, rwbdat);
         chk($sformatf("rnd%0d_in_ready", c), 32'(bus.in_ready), 32'(eRdy));
         chk($sformatf("rnd%0d_rf_write", c), 32'(bus.rf_write), 32'(rwbv));
         step();

         acc = rv && eRdy;
         if (rwbv) begin
            if (!pend[rwbd]) mErr = 1'b1;
            pend[rwbd] = 1'b0;
         end
         if (acc) begin
            mOut  = '{op1: eOp1, op2: eOp2, dr: rd, wen: rw};
            mOutV = 1'b1;
            if (rw) pend[rd] = 1'b1;
         end else if (mOutV && rordy) begin
            mOutV = 1'b0;
         end

         chk($sformatf("rnd%0d_out_valid", c), 32'(bus.out_valid), 32'(mOutV));
         chk($sformatf("rnd%0d_out_op1", c), bus.out_op1, mOut.op1);
         chk($sformatf("rnd%0d_out_op2", c), bus.out_op2, mOut.op2);
         chk($sformatf("rnd%0d_out_dr", c), 32'(bus.out_dr), 32'(mOut.dr));
         chk($sformatf("rnd%0d_out_wen", c), 32'(bus.out_wen), 32'(mOut.wen));
         chk($sformatf("rnd%0d_outstanding", c), 32'(bus.outstanding), 32'(popPend()));
         chk($sformatf("rnd%0d_sb_err", c), 32'(bus.sb_err), 32'(mErr));
      end

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read / writeback sequencer that drives the 32x32 register bank's read addresses, write port and write enable. Accepts decoded instructions on a valid/ready handshake, tracks in-flight destination registers in a scoreboard, stalls on RAW/WAW hazards, forwards same-cycle writeback data, and presents a registered operand bundle to the execute stage. Sits between decode and execute; writeback from execute returns through this block to the bank.

## Interface
- TOTAL_REG, 32, number of architectural registers
- WIDTH_REG, 32, register data width
- ADDR_W, 5, register index width (TOTAL_REG == 2**ADDR_W)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_sr1, in_sr2  in  ADDR_W  source register indices
- in_dr  in  ADDR_W  destination index
- in_wen  in  1  instruction writes in_dr
- rf_sr1, rf_sr2  out  ADDR_W  bank read addresses (= in_sr1, in_sr2, combinational)
- rf_rdData1, rf_rdData2  in  WIDTH_REG  bank combinational read data
- rf_write  out  1  bank write enable
- rf_dr  out  ADDR_W  bank write address
- rf_wrData  out  WIDTH_REG  bank write data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute accepts bundle
- out_op1, out_op2  out  WIDTH_REG  operands
- out_dr  out  ADDR_W  destination
- out_wen  out  1  destination write flag
- wb_valid  in  1  writeback from execute
- wb_dr  in  ADDR_W  writeback index
- wb_data  in  WIDTH_REG  writeback value
- outstanding  out  ADDR_W+1  count of pending destination registers
- sb_err  out  1  sticky: writeback to a register not marked pending

## Operation
- Scoreboard: pending[TOTAL_REG-1:0].
- hz1 = pending[in_sr1] && !(wb_valid && wb_dr==in_sr1); hz2 likewise for in_sr2; hzw = in_wen && pending[in_dr] (WAW always stalls, no bypass).
- in_ready = reset && (!out_valid || out_ready) && !hz1 && !hz2 && !hzw.
- Operand select: if wb_valid && wb_dr==in_srN then wb_data, else rf_rdDataN.
- Accept: out_op1/2, out_dr, out_wen loaded; out_valid<=1; if in_wen, pending[in_dr]<=1.
- Output drains when out_valid && out_ready and no accept: out_valid<=0; payload holds.
- Writeback: rf_write = reset && wb_valid; rf_dr = wb_dr; rf_wrData = wb_data (combinational). pending[wb_dr]<=0 on wb_valid.
- Same-cycle wb clear and accept set of the same index: set wins (pending stays 1).
- wb_valid with pending[wb_dr]==0: bank still written, pending unchanged, sb_err<=1 (cleared only by reset).
- outstanding = popcount-equivalent counter: +1 on accept with in_wen, -1 on wb_valid clearing a set bit; both same cycle: unchanged. Max TOTAL_REG.
- No hardwired-zero register; index 0 is ordinary.

## Timing
- Reset (reset==0 at posedge): out_valid=0, out_op1/2=0, out_dr=0, out_wen=0, pending=0, outstanding=0, sb_err=0. While reset==0: in_ready=0, rf_write=0.
- Accept-to-out_valid latency: 1 cycle (visible after the accepting edge).
- Full throughput 1/cycle with out_ready held high and no hazards.
- Dependent instruction: earliest accept is the cycle its producer's wb_valid is asserted (forwarded); next cycle reads bank directly.
- out_* payload stable while out_valid && !out_ready.
- Reset mid-operation discards the output bundle and all pending state; the bank itself is unaffected.

## Structure
- Shared package: TOTAL_REG, WIDTH_REG, ADDR_W constants; operand bundle struct {op1, op2, dr, wen}.
- One natural sub-module: operand_scoreboard (pending bits, hazard detect, outstanding counter, sb_err); operand_fetch keeps the handshake, forwarding mux and output register.

## Test plan
- Reset then bank preloaded r3=0x11, r4=0x22; issue sr1=3, sr2=4, dr=5, wen=1 -> next cycle out_op1=0x11, out_op2=0x22, out_dr=5, pending[5]=1, outstanding=1.
- RAW: after above, issue sr1=5 -> in_ready=0 until wb_valid dr=5 data=0xAB; that cycle accepted with out_op1=0xAB, outstanding 0.
- WAW: dr=7 pending, new instruction wen=1 dr=7 -> stalled until wb to 7; simultaneous wb 7 and accept dr=7 -> pending[7] stays 1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> payload unchanged, in_ready=0; release -> 1/cycle stream of 4 independent instructions.
- wb_valid dr=9 with pending[9]=0 -> rf_write=1, sb_err=1 and stays 1 until reset.
- Assert reset=0 with out_valid=1, 3 pending -> next cycle out_valid=0, outstanding=0, sb_err=0, rf_write=0 during reset.
